// File: rtl/ascon_serial_io.sv
`timescale 1ns/1ps
// Serial W-bit load/unload front-end for the Ascon AEAD core: shifts key, nonce,
// AD, text and expected tag in, pulses the core, then streams text and tag out.
module ascon_serial_io #(
  parameter int K = 128,
  parameter int L = 32,
  parameter int Y = 32,
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   key_i,
  input  logic [W-1:0]   nonce_i,
  input  logic [W-1:0]   ad_i,
  input  logic [W-1:0]   din_i,
  input  logic [W-1:0]   tag_i,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           mode_i,
  output logic [K-1:0]   core_key,
  output logic [127:0]   core_nonce,
  output logic [L-1:0]   core_ad,
  output logic [Y-1:0]   core_din,
  output logic           core_mode,
  output logic           core_start,
  input  logic [Y-1:0]   core_dout,
  input  logic [127:0]   core_tag,
  input  logic           core_done,
  output logic [W-1:0]   dout_o,
  output logic [W-1:0]   tagout_o,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           tag_ok,
  output logic           busy
);

  localparam int KL    = (K > L) ? K : L;
  localparam int YT    = (Y > 128) ? Y : 128;
  localparam int N_IN  = ((KL > YT) ? KL : YT) / W;
  localparam int N_OUT = 128 / W;
  localparam int CW    = $clog2(N_IN + 1);

  localparam logic [CW-1:0] NK       = CW'(K / W);
  localparam logic [CW-1:0] NN       = CW'(128 / W);
  localparam logic [CW-1:0] NL       = CW'(L / W);
  localparam logic [CW-1:0] NY       = CW'(Y / W);
  localparam logic [CW-1:0] LAST_IN  = CW'(N_IN - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(N_OUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;
  logic [127:0]  tag_exp;
  logic [Y-1:0]  dout_sr;
  logic [127:0]  tag_sr;
  logic          accept;

  assign in_ready   = (state == S_IDLE) || (state == S_LOAD);
  assign accept     = in_valid && in_ready;
  assign core_start = (state == S_START);
  assign out_valid  = (state == S_UNLOAD);
  assign busy       = (state != S_IDLE);
  assign dout_o     = dout_sr[Y-1 -: W];
  assign tagout_o   = tag_sr[127 -: W];
  // The beat accepted in IDLE is beat 0 regardless of the counter.
  assign idx        = (state == S_LOAD) ? cnt : '0;

  // Field registers: each stops shifting once its own beat count is reached,
  // and nothing writes them outside IDLE/LOAD so they stay put for the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_key   <= '0;
      core_nonce <= '0;
      core_ad    <= '0;
      core_din   <= '0;
      tag_exp    <= '0;
    end else if (accept) begin
      if (idx < NK) core_key   <= (core_key << W) | K'(key_i);
      if (idx < NN) core_nonce <= (core_nonce << W) | 128'(nonce_i);
      if (idx < NL) core_ad    <= (core_ad << W) | L'(ad_i);
      if (idx < NY) core_din   <= (core_din << W) | Y'(din_i);
      if (idx < NN) tag_exp    <= (tag_exp << W) | 128'(tag_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      core_mode <= 1'b0;
      tag_ok    <= 1'b0;
      dout_sr   <= '0;
      tag_sr    <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          core_mode <= mode_i;
          tag_ok    <= 1'b0;
          cnt       <= CW'(1);
          state     <= (LAST_IN == '0) ? S_START : S_LOAD;
        end
        S_LOAD: if (in_valid) begin
          if (cnt == LAST_IN) begin
            cnt   <= '0;
            state <= S_START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: if (core_done) begin
          dout_sr <= core_dout;
          tag_sr  <= core_tag;
          tag_ok  <= core_mode && (core_tag == tag_exp);
          cnt     <= '0;
          state   <= S_UNLOAD;
        end
        S_UNLOAD: if (out_ready) begin
          dout_sr <= dout_sr << W;
          tag_sr  <= tag_sr << W;
          if (cnt == LAST_OUT) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
